// File: rtl/ram_ctrl.sv
// Single-port register-file controller with write, read and clear-all
// operations, each completing with a one-cycle done pulse.
module ram_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             wen,
    input  logic             ren,
    input  logic             clr,
    input  logic [AW-1:0]    address,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CLEAR,
        DONE
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] data_q;
    logic             op_wr;
    logic             req;
    logic             bad;
    logic             last;

    always_comb begin
        req     = wen || ren;
        bad     = (wen && ren) || (32'(address) >= 32'(DEPTH));
        last    = (cnt == AW'(DEPTH - 1));
        state_n = state;
        unique case (state)
            IDLE: begin
                if (clr)
                    state_n = CLEAR;
                else if (req && !bad)
                    state_n = ACCESS;
            end
            ACCESS:  state_n = DONE;
            CLEAR:   if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state <= IDLE;
            err   <= 1'b0;
            Q     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            err   <= (state == IDLE) && !clr && req && bad;
            if (state == IDLE)
                cnt <= '0;
            else if (state == CLEAR)
                cnt <= cnt + AW'(1);
            if (state == ACCESS && !op_wr)
                Q <= mem[addr_q];
        end
    end

    // Request fields are captured every idle cycle; only the one taken
    // on the transition into ACCESS matters.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            addr_q <= address;
            data_q <= data;
            op_wr  <= wen;
        end
    end

    // No reset on storage; a reset edge suppresses any pending write.
    always_ff @(posedge clk) begin
        if (res) begin
            if (state == CLEAR)
                mem[cnt] <= '0;
            else if (state == ACCESS && op_wr)
                mem[addr_q] <= data_q;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: expected read data is queued at request
// time and compared when the done pulse arrives.
module tb_ram_ctrl;

    logic       clk = 1'b0;
    logic       res;
    logic       wen, ren, clr;
    logic [2:0] address;
    logic [3:0] data;
    logic [3:0] Q;
    logic       busy, done, err;

    int passed = 0;
    int total  = 0;

    logic [3:0] model [8];
    logic [3:0] sb [$];

    ram_ctrl #(.WIDTH(4), .DEPTH(8)) dut (
        .clk(clk), .res(res), .wen(wen), .ren(ren), .clr(clr),
        .address(address), .data(data), .Q(Q),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Drive one request, then follow it until busy drops (bounded).
    task automatic req(input bit w, input bit r, input bit c,
                       input logic [2:0] a, input logic [3:0] d,
                       output int bcyc, output bit got_done,
                       output logic [3:0] qd, output bit got_err);
        @(negedge clk);
        wen = w; ren = r; clr = c; address = a; data = d;
        @(negedge clk);
        wen = 0; ren = 0; clr = 0;
        bcyc = 0; got_done = 0; qd = 'x; got_err = err;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            bcyc++;
            if (done) begin
                got_done = 1;
                qd = Q;
            end
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        int b; bit g; logic [3:0] q; bit e;
        req(1, 0, 0, a, d, b, g, q, e);
        model[a] = d;
    endtask

    task automatic test_reset;
        res = 0; wen = 0; ren = 0; clr = 0; address = 0; data = 0;
        repeat (3) @(negedge clk);
        total++;
        if (Q !== 4'h0) $display("FAIL reset_q: got %h want 0", Q);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
        else passed++;
        total++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err);
        else passed++;
        res = 1;
    endtask

    task automatic test_write_read;
        int b; bit g; logic [3:0] q; bit e; logic [3:0] exp;
        req(1, 0, 0, 3'd3, 4'hA, b, g, q, e);
        model[3] = 4'hA;
        total++;
        if (b !== 2 || !g)
            $display("FAIL wr_timing: busy %0d done %b want 2 1", b, g);
        else passed++;
        sb.push_back(model[3]);
        req(0, 1, 0, 3'd3, 4'h0, b, g, q, e);
        total++;
        if (b !== 2 || !g)
            $display("FAIL rd_timing: busy %0d done %b want 2 1", b, g);
        else passed++;
        exp = sb.pop_front();
        total++;
        if (q !== exp) $display("FAIL rd_data: got %h want %h", q, exp);
        else passed++;
        repeat (2) @(negedge clk);
        total++;
        if (Q !== exp) $display("FAIL q_hold: got %h want %h", Q, exp);
        else passed++;
    endtask

    task automatic test_clear;
        int b; bit g; logic [3:0] q; bit e; logic [3:0] exp;
        for (int i = 0; i < 8; i++) wr(3'(i), 4'hF);
        req(0, 0, 1, 3'd0, 4'h0, b, g, q, e);
        for (int i = 0; i < 8; i++) model[i] = 4'h0;
        total++;
        if (b !== 9 || !g)
            $display("FAIL clr_timing: busy %0d done %b want 9 1", b, g);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(model[i]);
            req(0, 1, 0, 3'(i), 4'h0, b, g, q, e);
            exp = sb.pop_front();
            total++;
            if (q !== exp || !g)
                $display("FAIL clr_rd%0d: got %h want %h", i, q, exp);
            else passed++;
        end
    endtask

    task automatic test_walking_ones;
        int b; bit g; logic [3:0] q; bit e; logic [3:0] exp;
        int bad;
        for (int a = 0; a < 8; a++) begin
            for (int j = 0; j < 4; j++) begin
                wr(3'(a), 4'(1 << j));
                bad = 0;
                for (int k = 0; k < 8; k++) begin
                    sb.push_back(model[k]);
                    req(0, 1, 0, 3'(k), 4'h0, b, g, q, e);
                    exp = sb.pop_front();
                    total++;
                    if (q !== exp) begin
                        $display("FAIL walk a%0d b%0d r%0d: got %h want %h",
                                 a, j, k, q, exp);
                        bad++;
                    end else passed++;
                end
            end
            wr(3'(a), 4'h0);
        end
    endtask

    task automatic test_illegal;
        int b; bit g; logic [3:0] q; bit e; logic [3:0] exp;
        wr(3'd2, 4'h6);
        req(1, 1, 0, 3'd2, 4'h9, b, g, q, e);
        total++;
        if (e !== 1'b1 || b !== 0)
            $display("FAIL ill_err: err %b busy %0d want 1 0", e, b);
        else passed++;
        @(negedge clk);
        total++;
        if (err !== 1'b0) $display("FAIL ill_pulse: err %b want 0", err);
        else passed++;
        sb.push_back(model[2]);
        req(0, 1, 0, 3'd2, 4'h0, b, g, q, e);
        exp = sb.pop_front();
        total++;
        if (q !== exp) $display("FAIL ill_mem: got %h want %h", q, exp);
        else passed++;
    endtask

    task automatic test_ignore_busy;
        int b; bit g; logic [3:0] q; bit e; logic [3:0] exp;
        wr(3'd5, 4'h3);
        @(negedge clk);
        ren = 1; address = 3'd1;
        @(negedge clk);
        ren = 0;
        @(negedge clk);
        total++;
        if (done !== 1'b1) $display("FAIL ign_done: got %b want 1", done);
        else passed++;
        wen = 1; address = 3'd5; data = 4'h7;
        @(negedge clk);
        wen = 0;
        total++;
        if (busy !== 1'b0) $display("FAIL ign_busy: got %b want 0", busy);
        else passed++;
        sb.push_back(model[5]);
        req(0, 1, 0, 3'd5, 4'h0, b, g, q, e);
        exp = sb.pop_front();
        total++;
        if (q !== exp) $display("FAIL ign_mem: got %h want %h", q, exp);
        else passed++;
    endtask

    task automatic test_reset_mid_clear;
        int b; bit g; logic [3:0] q; bit e; logic [3:0] exp;
        for (int i = 0; i < 8; i++) wr(3'(i), 4'hF);
        req(0, 1, 0, 3'd7, 4'h0, b, g, q, e);
        @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        repeat (3) @(negedge clk);
        res = 0;
        @(negedge clk);
        res = 1;
        total++;
        if (Q !== 4'h0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rmc_outs: Q %h busy %b done %b want 0 0 0",
                     Q, busy, done);
        else passed++;
        for (int i = 0; i < 3; i++) model[i] = 4'h0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(model[i]);
            req(0, 1, 0, 3'(i), 4'h0, b, g, q, e);
            exp = sb.pop_front();
            total++;
            if (q !== exp) $display("FAIL rmc_rd%0d: got %h want %h", i, q, exp);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_clear;
        test_walking_ones;
        test_illegal;
        test_ignore_busy;
        test_reset_mid_clear;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, the number of words; AW = $clog2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port res, input, 1, synchronous active-low reset sampled on the clk rising edge.
REQ-005 The block SHALL have port wen, input, 1, the write request.
REQ-006 The block SHALL have port ren, input, 1, the read request.
REQ-007 The block SHALL have port clr, input, 1, the clear-all request.
REQ-008 The block SHALL have port address, input, AW, the request word address.
REQ-009 The block SHALL have port data, input, WIDTH, the write data.
REQ-010 The block SHALL have port Q, output, WIDTH, the registered read data.
REQ-011 The block SHALL have port busy, output, 1, high while a request is in progress.
REQ-012 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-013 The block SHALL have port err, output, 1, a one-cycle illegal-request pulse.

Function
REQ-014 The block SHALL implement states IDLE, ACCESS, CLEAR and DONE, with internal storage of DEPTH x WIDTH registers.
REQ-015 Requests SHALL be sampled only in IDLE; wen, ren and clr SHALL be ignored in all other states.
REQ-016 IDLE request priority SHALL be clr, then wen&&ren, then wen, then ren.
REQ-017 In IDLE, wen&&ren with clr low SHALL pulse err for 1 cycle, perform no access, and stay in IDLE.
REQ-018 In IDLE, a single wen or ren SHALL latch address, data and op type, and SHALL move to ACCESS.
REQ-019 In ACCESS, a write SHALL store the latched data at the latched address on the next edge; Q SHALL be unchanged.
REQ-020 In ACCESS, a read SHALL load Q with mem[latched address] on the next edge; the state SHALL then be DONE.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE on the next edge.
REQ-022 Latency SHALL be a request sampled at edge N, data written or Q valid after edge N+1, and done high between edges N+1 and N+2.
REQ-023 busy SHALL be high in ACCESS, CLEAR and DONE, and low in IDLE.
REQ-024 In IDLE, clr SHALL start an internal counter at 0 and move to CLEAR.
REQ-025 In CLEAR, the block SHALL write 0 to mem[counter] each cycle and increment the counter.
REQ-026 On the edge that writes address DEPTH-1, CLEAR SHALL move to DONE; a clear SHALL take DEPTH cycles plus 1 DONE cycle.
REQ-027 The clear counter SHALL terminate correctly when DEPTH is not a power of 2, never writing at or beyond DEPTH.
REQ-028 An address >= DEPTH in a request SHALL pulse err, perform no access, and stay in IDLE.
REQ-029 Q SHALL hold its last read value until the next read completes or reset.
REQ-030 err SHALL be 0 in all states other than the cycle after an illegal IDLE request.

Reset
REQ-031 When res=0 at an edge, the state SHALL become IDLE and Q, busy, done and err SHALL become 0.
REQ-032 Reset SHALL not clear memory contents; storage content after power-up without clr SHALL be undefined.
REQ-033 Reset during ACCESS or CLEAR SHALL abort the operation with no further writes; words already cleared SHALL stay 0.
REQ-034 Requests present on the first edge with res=1 SHALL be sampled normally.

Verification
REQ-035 The bench SHALL cover write/read: write addr 3 data 0xA; read addr 3 -> Q=0xA two edges after the read request, with done high 1 cycle and busy high 2 cycles.
REQ-036 The bench SHALL cover walking ones: for each addr 0..7 and bit j, write 2**j then read back the whole memory -> only that word differs from the model.
REQ-037 The bench SHALL cover clear: fill all words with 0xF, pulse clr -> busy for 9 cycles, done on the 9th cycle, all reads return 0.
REQ-038 The bench SHALL cover an illegal request: wen=ren=1 at addr 2 -> err for 1 cycle, busy=0, and mem[2] unchanged on readback.
REQ-039 The bench SHALL cover ignore-while-busy: assert wen addr 5 data 0x7 during DONE of a prior read -> no write, mem[5] unchanged.
REQ-040 The bench SHALL cover reset mid-clear: drive res=0 on the 4th CLEAR cycle -> addrs 0-2 read 0, addrs 3-7 keep 0xF, and Q/busy/done are 0.
